// File: rtl/pipeline_stage_buf.sv
// Generic inter-stage register with valid/ready handshake, optional one-entry
// skid buffer, synchronous flush, global hold and a saturating stall counter.
module pipeline_stage_buf #(
  parameter int WIDTH   = 104,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             in_fire, out_fire;

  assign out_valid = main_vld_q & ~hold;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
  assign stall_cnt = stall_cnt_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // With the skid entry, in_ready is a pure function of registered state and
  // hold, which breaks the ready path from downstream.
  generate
    if (SKID_EN != 0) begin : g_skid
      assign in_ready = ~hold & ~skid_vld_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          skid_vld_q  <= 1'b0;
          skid_data_q <= '0;
        end else begin
          skid_vld_q  <= skid_vld_d;
          skid_data_q <= skid_data_d;
        end
      end
    end else begin : g_noskid
      assign in_ready    = ~hold & (~main_vld_q | out_ready);
      assign skid_vld_q  = 1'b0;
      assign skid_data_q = '0;
    end
  endgenerate

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (!main_vld_q) begin
      if (in_fire) begin
        main_vld_d  = 1'b1;
        main_data_d = in_data;
      end
    end else if (!skid_vld_q) begin
      if (in_fire && out_fire) begin
        main_data_d = in_data;
      end else if (in_fire) begin
        skid_vld_d  = 1'b1;
        skid_data_d = in_data;
      end else if (out_fire) begin
        main_vld_d = 1'b0;
      end
    end else if (out_fire) begin
      main_data_d = skid_data_q;
      skid_vld_d  = 1'b0;
    end
    // Flush kills entries only; payload registers keep their contents.
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_vld_q && !out_ready && !hold && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
